// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer for a small accumulator machine: fetches
// one- and two-byte instructions from a byte ROM and drives the datapath controls.
module control_unit #(
  parameter int PC_WIDTH = 5  // must not exceed 8: jump targets come from the 8-bit operand
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic [7:0]          instr_data,
  input  logic                enter,
  input  logic                zero_flag,
  input  logic                positive_flag,
  output logic [1:0]          mux_select,
  output logic [7:0]          imm_data,
  output logic                acc_enable,
  output logic [2:0]          rf_address,
  output logic                rf_write,
  output logic [3:0]          alu_select,
  output logic [1:0]          alu_num_rotate,
  output logic                output_enable,
  output logic                halted,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXECUTE = 3'd3,
    S_WAIT_IN = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'd1;
  localparam logic [3:0] OP_STA  = 4'd2;
  localparam logic [3:0] OP_LDI  = 4'd3;
  localparam logic [3:0] OP_IN   = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_JP   = 4'd8;
  localparam logic [3:0] OP_ALU  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          ir, opr;
  logic                zf_latched, pf_latched;
  logic                enter_q;
  logic [3:0]          op;
  logic                two_byte, enter_rise, branch_taken;
  logic                unused_ir_bit;

  assign op            = ir[7:4];
  assign two_byte      = (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) ||
                         (op == OP_JP)  || (op == OP_ALU);
  assign enter_rise    = enter && !enter_q;
  assign branch_taken  = (op == OP_JMP) || ((op == OP_JZ) && zf_latched) ||
                         ((op == OP_JP) && pf_latched);
  assign unused_ir_bit = ir[3];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Reset-to-flags-set lets a JZ/JP before any accumulator load be taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc         <= '0;
      ir         <= '0;
      opr        <= '0;
      zf_latched <= 1'b1;
      pf_latched <= 1'b1;
      enter_q    <= 1'b0;
    end else begin
      enter_q <= enter;
      if (acc_enable) begin
        zf_latched <= zero_flag;
        pf_latched <= positive_flag;
      end
      case (state)
        S_FETCH: begin
          ir <= instr_data;
          pc <= pc + PC_WIDTH'(1);
        end
        S_OPERAND: begin
          opr <= instr_data;
          pc  <= pc + PC_WIDTH'(1);
        end
        S_EXECUTE: if (branch_taken) pc <= opr[PC_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE: begin
        if (op == OP_HALT)    state_nxt = S_HALT;
        else if (op == OP_IN) state_nxt = S_WAIT_IN;
        else if (two_byte)    state_nxt = S_OPERAND;
        else                  state_nxt = S_EXECUTE;
      end
      S_OPERAND: state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = S_FETCH;
      S_WAIT_IN: state_nxt = enter_rise ? S_FETCH : S_WAIT_IN;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    instr_addr     = pc;
    rf_address     = ir[2:0];
    halted         = (state == S_HALT);
    state_out      = state;
    mux_select     = 2'd0;
    imm_data       = 8'd0;
    acc_enable     = 1'b0;
    rf_write       = 1'b0;
    alu_select     = 4'd0;
    alu_num_rotate = 2'd0;
    output_enable  = 1'b0;
    if (state == S_EXECUTE) begin
      case (op)
        OP_LDA: begin
          mux_select = 2'd1;
          acc_enable = 1'b1;
        end
        OP_STA: rf_write = 1'b1;
        OP_LDI: begin
          mux_select = 2'd2;
          imm_data   = opr;
          acc_enable = 1'b1;
        end
        OP_OUT: output_enable = 1'b1;
        OP_ALU: begin
          alu_select     = opr[3:0];
          alu_num_rotate = opr[5:4];
          acc_enable     = 1'b1;
        end
        default: ;
      endcase
    end else if ((state == S_WAIT_IN) && enter_rise) begin
      mux_select = 2'd3;
      acc_enable = 1'b1;
    end
  end

endmodule
